hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It sits beside the ID-stage decoder and selects forwarding sources for both ID operands. It detects load-use and HI/LO hazards and tracks multi-cycle multiply/divide occupancy. It generalises the fixed two-source forwarding logic to NSRC producer stages and adds a multiply/divide busy state machine.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/mdu_tracker.sv | 75 +++++++
 rtl/hazard_unit.sv | 103 ++++++++++
 tb/tb_hazard_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the ID-stage hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int unsigned FWD_RF = 0;

    // Select width for NSRC producers plus the regfile choice.
    function automatic int unsigned sel_width(input int unsigned nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

    // Counter width that holds max(a, b) - 1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Multiply/divide occupancy tracker: IDLE -> BUSY (LAT cycles) -> DONE (one cycle).
module mdu_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 33
) (
    input  logic clk,
    input  logic resetn,
    input  logic accept_i,
    input  logic div_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned CNTW = cnt_width(MULT_LAT, DIV_LAT);

    mdu_state_t       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             busy_q, done_q;
    logic [CNTW-1:0]  load_val;

    assign load_val = div_i ? CNTW'(DIV_LAT - 1) : CNTW'(MULT_LAT - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == BUSY);
            done_q  <= (state_d == DONE);
        end
    end

    // Next state; the counter only moves downward and holds at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_i) begin
                    state_d = BUSY;
                    cnt_d   = load_val;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (accept_i) begin
                    state_d = BUSY;
                    cnt_d   = load_val;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage forwarding select, load-use / HI-LO hazard detection and MDU occupancy.
// Optional branch-likely delay-slot annul is enabled by defining HAZ_BRANCH_LIKELY_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int unsigned NSRC       = 2,
    parameter  int unsigned LOAD_STAGE = 1,
    parameter  int unsigned MULT_LAT   = 4,
    parameter  int unsigned DIV_LAT    = 33,
    localparam int unsigned SELW       = sel_width(NSRC)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_mdu_start,
    input  logic              id_mdu_div,
    input  logic              id_hilo_read,
    input  logic              id_likely,
    input  logic              id_br_taken,
    input  logic [NSRC-1:0]   src_wen,
    input  logic [5*NSRC-1:0] src_reg,
    input  logic [NSRC-1:0]   src_is_load,
    output logic [SELW-1:0]   fwd_a,
    output logic [SELW-1:0]   fwd_b,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              flush_slot,
    output logic              mdu_busy,
    output logic              mdu_done
);

    // Returns {load_use, select}; the youngest matching producer wins.
    function automatic logic [SELW:0] lookup(
        input logic [4:0]        r,
        input logic              use_r,
        input logic [NSRC-1:0]   wen,
        input logic [5*NSRC-1:0] regs,
        input logic [NSRC-1:0]   ld
    );
        logic            hit;
        logic            lu;
        logic [SELW-1:0] sel;
        hit = 1'b0;
        lu  = 1'b0;
        sel = SELW'(FWD_RF);
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (!hit && use_r && (r != 5'd0) && wen[k] && (regs[5*k +: 5] == r)) begin
                hit = 1'b1;
                if (ld[k] && (k < LOAD_STAGE)) begin
                    lu = 1'b1;
                end else begin
                    sel = SELW'(k + 1);
                end
            end
        end
        return {lu, sel};
    endfunction

    logic [SELW:0] res_a, res_b;
    logic          load_use;
    logic          mdu_haz;
    logic          accept;

    always_comb begin
        res_a = lookup(id_rs, id_use_rs, src_wen, src_reg, src_is_load);
        res_b = lookup(id_rt, id_use_rt, src_wen, src_reg, src_is_load);
    end

    assign fwd_a    = res_a[SELW-1:0];
    assign fwd_b    = res_b[SELW-1:0];
    assign load_use = res_a[SELW] | res_b[SELW];

    // HI/LO results are readable once the tracker reaches DONE.
    assign mdu_haz  = mdu_busy & (id_mdu_start | id_hilo_read);
    assign stall_id = id_valid & (load_use | mdu_haz);
    assign flush_ex = stall_id;
    assign accept   = id_valid & id_mdu_start & ~stall_id;

`ifdef HAZ_BRANCH_LIKELY_EN
    assign flush_slot = id_valid & id_likely & ~id_br_taken & ~stall_id;
`else
    logic unused_bl;
    assign unused_bl  = id_likely ^ id_br_taken;
    assign flush_slot = 1'b0;
`endif

    mdu_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu (
        .clk      (clk),
        .resetn   (resetn),
        .accept_i (accept),
        .div_i    (id_mdu_div),
        .busy_o   (mdu_busy),
        .done_o   (mdu_done)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized cycles vs a timestamp model.
module tb_hazard_unit;

    localparam int unsigned NSRC       = 2;
    localparam int unsigned LOAD_STAGE = 1;
    localparam int unsigned MULT_LAT   = 4;
    localparam int unsigned DIV_LAT    = 33;
    localparam int unsigned SELW       = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt;
    logic              id_use_rs, id_use_rt;
    logic              id_mdu_start, id_mdu_div, id_hilo_read;
    logic              id_likely, id_br_taken;
    logic [NSRC-1:0]   src_wen;
    logic [5*NSRC-1:0] src_reg;
    logic [NSRC-1:0]   src_is_load;
    logic [SELW-1:0]   fwd_a, fwd_b;
    logic              stall_id, flush_ex, flush_slot, mdu_busy, mdu_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // MDU model: last accepted operation, by cycle number and latency.
    bit m_active;
    int m_start;
    int m_lat;

    always #5 clk = ~clk;

    hazard_unit #(
        .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div), .id_hilo_read(id_hilo_read),
        .id_likely(id_likely), .id_br_taken(id_br_taken),
        .src_wen(src_wen), .src_reg(src_reg), .src_is_load(src_is_load),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_id(stall_id), .flush_ex(flush_ex),
        .flush_slot(flush_slot), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_mdu_start = 0; id_mdu_div = 0; id_hilo_read = 0;
        id_likely = 0; id_br_taken = 0;
        src_wen = 0; src_reg = 0; src_is_load = 0;
    endtask

    function automatic bit model_busy(input int c);
        return m_active && (c > m_start) && (c <= m_start + m_lat);
    endfunction

    function automatic bit model_done(input int c);
        return m_active && (c == m_start + m_lat + 1);
    endfunction

    // Matching producers in age order; the first one decides.
    function automatic void ref_fwd(input logic [4:0] x, input logic use_x, output int sel, output bit haz);
        int hits[$];
        sel = 0;
        haz = 0;
        if (use_x && x != 5'd0) begin
            for (int k = 0; k < int'(NSRC); k++)
                if (src_wen[k] && src_reg[5*k +: 5] == x) hits.push_back(k);
            if (hits.size() > 0) begin
                if (src_is_load[hits[0]] && hits[0] < int'(LOAD_STAGE)) haz = 1;
                else sel = hits[0] + 1;
            end
        end
    endfunction

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        m_active = 0;
        next_cycle();
        next_cycle();
        resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        m_active = 0;
        #2;
        checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", mdu_done); end
        next_cycle();
        resetn = 1;
        @(negedge clk);
        checks++;
        if ({fwd_a, fwd_b, stall_id, flush_ex, flush_slot, mdu_busy, mdu_done} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {fwd_a, fwd_b, stall_id, flush_ex, flush_slot, mdu_busy, mdu_done});
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        id_valid = 1; id_rs = 5'd8; id_use_rs = 1;
        src_wen = 2'b11; src_reg = {5'd8, 5'd8};
        @(negedge clk);
        checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL fwd_youngest got=%0d exp=1", fwd_a); end
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL fwd_nostall got=%0d exp=0", stall_id); end
        next_cycle();
        src_wen = 2'b10; src_reg = {5'd8, 5'd3};
        @(negedge clk);
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL fwd_older got=%0d exp=2", fwd_a); end
        next_cycle();
        id_rs = 5'd0; src_wen = 2'b01; src_reg = {5'd0, 5'd0};
        @(negedge clk);
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL fwd_r0 got=%0d exp=0", fwd_a); end
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL r0_nostall got=%0d exp=0", stall_id); end
        next_cycle();
        id_rs = 5'd8; id_use_rs = 0; src_reg = {5'd0, 5'd8};
        @(negedge clk);
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL fwd_unused got=%0d exp=0", fwd_a); end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; id_rt = 5'd9; id_use_rt = 1;
        src_wen = 2'b01; src_reg = {5'd0, 5'd9}; src_is_load = 2'b01;
        @(negedge clk);
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall_id); end
        checks++; if (flush_ex !== 1'b1) begin failures++; $display("FAIL lu_flush got=%0d exp=1", flush_ex); end
        checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL lu_fwd got=%0d exp=0", fwd_b); end
        next_cycle();
        src_wen = 2'b10; src_reg = {5'd9, 5'd0}; src_is_load = 2'b10;
        @(negedge clk);
        checks++; if (fwd_b !== 2'd2) begin failures++; $display("FAIL lu_moved_fwd got=%0d exp=2", fwd_b); end
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_moved_stall got=%0d exp=0", stall_id); end
        next_cycle();
        src_wen = 2'b11; src_reg = {5'd9, 5'd9}; src_is_load = 2'b10;
        @(negedge clk);
        checks++; if (fwd_b !== 2'd1) begin failures++; $display("FAIL young_over_load got=%0d exp=1", fwd_b); end
        next_cycle();
        // Load-use plus MDU start: not accepted, retried next cycle.
        src_wen = 2'b01; src_reg = {5'd0, 5'd9}; src_is_load = 2'b01; id_mdu_start = 1;
        @(negedge clk);
        checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_mdu_stall got=%0d exp=1", stall_id); end
        next_cycle();
        src_wen = 0; src_is_load = 0;
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL lu_mdu_notaccepted got=%0d exp=0", mdu_busy); end
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_mdu_retry got=%0d exp=0", stall_id); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b1) begin failures++; $display("FAIL lu_mdu_accepted got=%0d exp=1", mdu_busy); end
        for (int i = 0; i < 6; i++) next_cycle();
    endtask

    task automatic test_mdu_mult();
        clear_inputs();
        id_valid = 1; id_mdu_start = 1;
        @(negedge clk);
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL mult_accept_stall got=%0d exp=0", stall_id); end
        next_cycle();
        for (int i = 1; i <= 6; i++) begin
            clear_inputs();
            id_valid = (i == 2 || i == 5); id_hilo_read = id_valid;
            @(negedge clk);
            checks++;
            if (mdu_busy !== (i <= 4)) begin failures++; $display("FAIL mult_busy t+%0d got=%0d exp=%0d", i, mdu_busy, i <= 4); end
            checks++;
            if (mdu_done !== (i == 5)) begin failures++; $display("FAIL mult_done t+%0d got=%0d exp=%0d", i, mdu_done, i == 5); end
            checks++;
            if (stall_id !== (i == 2)) begin failures++; $display("FAIL mfhi_stall t+%0d got=%0d exp=%0d", i, stall_id, i == 2); end
            next_cycle();
        end
    endtask

    task automatic test_div_reset();
        clear_inputs();
        id_valid = 1; id_mdu_start = 1; id_mdu_div = 1;
        next_cycle();
        clear_inputs();
        for (int i = 1; i < 5; i++) next_cycle();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%0d exp=1", mdu_busy); end
        next_cycle();
        resetn = 0;
        #1;
        checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL div_reset_busy got=%0d exp=0", mdu_busy); end
        next_cycle();
        resetn = 1;
        id_valid = 1; id_mdu_start = 1;
        @(negedge clk);
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL post_reset_accept got=%0d exp=0", stall_id); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (mdu_busy !== 1'b1) begin failures++; $display("FAIL post_reset_busy got=%0d exp=1", mdu_busy); end
        for (int i = 0; i < 6; i++) next_cycle();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        id_valid = 1; id_mdu_start = 1;
        next_cycle();
        clear_inputs();
        for (int i = 1; i <= 4; i++) next_cycle();
        id_valid = 1; id_mdu_start = 1;
        @(negedge clk);
        checks++; if (mdu_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", mdu_done); end
        checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_id); end
        next_cycle();
        clear_inputs();
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            checks++;
            if ({mdu_busy, mdu_done} !== {1'(j <= 4), 1'(j == 5)}) begin
                failures++;
                $display("FAIL b2b_seq j=%0d got=%b exp=%b", j, {mdu_busy, mdu_done}, {1'(j <= 4), 1'(j == 5)});
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_likely();
        bit exp_on;
`ifdef HAZ_BRANCH_LIKELY_EN
        exp_on = 1;
`else
        exp_on = 0;
`endif
        clear_inputs();
        id_valid = 1; id_likely = 1; id_br_taken = 0;
        @(negedge clk);
        checks++; if (flush_slot !== exp_on) begin failures++; $display("FAIL bl_nottaken got=%0d exp=%0d", flush_slot, exp_on); end
        next_cycle();
        id_br_taken = 1;
        @(negedge clk);
        checks++; if (flush_slot !== 1'b0) begin failures++; $display("FAIL bl_taken got=%0d exp=0", flush_slot); end
        next_cycle();
        id_br_taken = 0; id_rs = 5'd4; id_use_rs = 1;
        src_wen = 2'b01; src_reg = {5'd0, 5'd4}; src_is_load = 2'b01;
        @(negedge clk);
        checks++; if (flush_slot !== 1'b0) begin failures++; $display("FAIL bl_stalled got=%0d exp=0", flush_slot); end
        next_cycle();
    endtask

    task automatic test_random();
        int ea, eb;
        bit ha, hb, e_stall, e_slot, e_busy, e_done;
        logic [8:0] exp_v, got_v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_mdu_start = ($urandom_range(0, 7) == 0);
            id_mdu_div   = ($urandom_range(0, 3) == 0);
            id_hilo_read = ($urandom_range(0, 3) == 0);
            id_likely    = 1'($urandom_range(0, 1));
            id_br_taken  = 1'($urandom_range(0, 1));
            src_wen      = 2'($urandom_range(0, 3));
            src_is_load  = 2'($urandom_range(0, 3));
            src_reg      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ref_fwd(id_rs, id_use_rs, ea, ha);
            ref_fwd(id_rt, id_use_rt, eb, hb);
            e_busy  = model_busy(cyc);
            e_done  = model_done(cyc);
            e_stall = id_valid && (ha || hb || (e_busy && (id_mdu_start || id_hilo_read)));
`ifdef HAZ_BRANCH_LIKELY_EN
            e_slot  = id_valid && id_likely && !id_br_taken && !e_stall;
`else
            e_slot  = 0;
`endif
            exp_v = {2'(ea), 2'(eb), e_stall, e_stall, e_slot, e_busy, e_done};
            @(negedge clk);
            got_v = {fwd_a, fwd_b, stall_id, flush_ex, flush_slot, mdu_busy, mdu_done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
            end
            if (id_valid && id_mdu_start && !e_stall) begin
                m_active = 1;
                m_start  = cyc;
                m_lat    = id_mdu_div ? int'(DIV_LAT) : int'(MULT_LAT);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        resetn = 1;
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu_mult();
        test_div_reset();
        test_back_to_back();
        test_branch_likely();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
